// File: rtl/branch_resolve_pipe.sv
// Branch/jump resolution pipeline: carries fetch prediction metadata through IF/ID, ID/EX, EX/MEM
// and drives the predictor's commit interface. Optional perf counters under `BR_PERF_CNT_EN`.
module branch_resolve_pipe #(
    parameter int PHT_INDEX_WIDTH = 6,
    parameter int BTB_INDEX_WIDTH = 6
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [31:0]                     IF_pc_i,
    input  logic                            IF_valid_i,
    input  logic                            IF_btb_hit_i,
    input  logic                            IF_prediction_i,
    input  logic [31:0]                     IF_btb_target_i,
    input  logic                            stall_i,
    input  logic                            flush_i,
    input  logic                            ID_is_br_i,
    input  logic                            ID_is_jal_i,
    input  logic                            ID_is_jalr_i,
    input  logic [2:0]                      ID_funct3_i,
    input  logic [31:0]                     ID_imm_i,
    input  logic [31:0]                     EX_rs1_i,
    input  logic [31:0]                     EX_rs2_i,
    output logic [BTB_INDEX_WIDTH-1:0]      EXMEM_btb_wr_index_o,
    output logic [PHT_INDEX_WIDTH-1:0]      EXMEM_pht_wr_index_o,
    output logic [31-BTB_INDEX_WIDTH-2:0]   EXMEM_btb_wr_tag_o,
    output logic [31:0]                     EXMEM_btb_wr_target_o,
    output logic                            EXMEM_btb_hit_o,
    output logic                            EXMEM_br_decision_o,
    output logic                            EXMEM_is_jmp_o,
    output logic                            EXMEM_prediction_o,
    output logic [31:0]                     EXMEM_pc_plus4_o,
    output logic [31:0]                     EXMEM_br_target_o,
    output logic [31:0]                     perf_br_cnt_o,
    output logic [31:0]                     perf_mispred_cnt_o
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        btb_hit;
        logic        pred;
        logic [31:0] btb_target;
    } ifid_t;

    typedef struct packed {
        ifid_t       f;
        logic        is_br;
        logic        is_jal;
        logic        is_jalr;
        logic [2:0]  funct3;
        logic [31:0] imm;
    } idex_t;

    typedef struct packed {
        logic        valid;
        logic [29:0] pc_w;
        logic        btb_hit;
        logic        is_jmp;
        logic        decision;
        logic        pred;
        logic [31:0] target;
        logic [31:0] pc_plus4;
    } exmem_t;

    ifid_t  ifid_q,  ifid_d;
    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;

    logic        ex_eq, ex_lt, ex_ltu, ex_cond, ex_is_jmp, ex_taken;
    logic [31:0] ex_target, ex_jalr_sum;

    // EX: direction compare and target adder on the instruction held in ID/EX.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ex_cond     = 1'b0;
        ex_eq       = (EX_rs1_i == EX_rs2_i);
        ex_lt       = ($signed(EX_rs1_i) < $signed(EX_rs2_i));
        ex_ltu      = (EX_rs1_i < EX_rs2_i);
        case (idex_q.funct3)
            3'b000:  ex_cond = ex_eq;
            3'b001:  ex_cond = !ex_eq;
            3'b100:  ex_cond = ex_lt;
            3'b101:  ex_cond = !ex_lt;
            3'b110:  ex_cond = ex_ltu;
            3'b111:  ex_cond = !ex_ltu;
            default: ex_cond = 1'b0;
        endcase
        ex_is_jmp   = idex_q.f.valid && (idex_q.is_br || idex_q.is_jal || idex_q.is_jalr);
        ex_taken    = idex_q.is_jal || idex_q.is_jalr || (idex_q.is_br && ex_cond);
        ex_jalr_sum = EX_rs1_i + idex_q.imm;
        ex_target   = idex_q.is_jalr ? (ex_jalr_sum & ~32'h1) : (idex_q.f.pc + idex_q.imm);
    end

    always_comb begin
        ifid_d  = ifid_q;
        idex_d  = idex_q;
        exmem_d = '0;
        if (flush_i) begin
            ifid_d = '0;
            idex_d = '0;
        end else if (!stall_i) begin
            ifid_d.valid      = IF_valid_i;
            ifid_d.pc         = IF_pc_i;
            ifid_d.btb_hit    = IF_btb_hit_i;
            ifid_d.pred       = IF_prediction_i;
            ifid_d.btb_target = IF_btb_target_i;

            idex_d.f       = ifid_q;
            idex_d.is_br   = ID_is_br_i;
            idex_d.is_jal  = ID_is_jal_i;
            idex_d.is_jalr = ID_is_jalr_i;
            idex_d.funct3  = ID_funct3_i;
            idex_d.imm     = ID_imm_i;

            exmem_d.valid    = idex_q.f.valid;
            exmem_d.pc_w     = idex_q.f.pc[31:2];
            exmem_d.btb_hit  = idex_q.f.btb_hit;
            exmem_d.is_jmp   = ex_is_jmp;
            exmem_d.decision = ex_is_jmp && ex_taken;
            // A taken prediction to the wrong target is demoted so the predictor redirects.
            exmem_d.pred     = idex_q.f.pred &&
                               !(ex_is_jmp && ex_taken && (idex_q.f.btb_target != ex_target));
            exmem_d.target   = ex_target;
            exmem_d.pc_plus4 = idex_q.f.pc + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
        if (rst_i) begin
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
        end else begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
        end
    end

    assign EXMEM_btb_wr_index_o  = exmem_q.pc_w[BTB_INDEX_WIDTH-1:0];
    assign EXMEM_pht_wr_index_o  = exmem_q.pc_w[PHT_INDEX_WIDTH-1:0];
    assign EXMEM_btb_wr_tag_o    = exmem_q.pc_w[29:BTB_INDEX_WIDTH];
    assign EXMEM_btb_wr_target_o = exmem_q.target;
    assign EXMEM_br_target_o     = exmem_q.target;
    assign EXMEM_pc_plus4_o      = exmem_q.pc_plus4;
    assign EXMEM_btb_hit_o       = exmem_q.valid && exmem_q.btb_hit;
    assign EXMEM_is_jmp_o        = exmem_q.valid && exmem_q.is_jmp;
    assign EXMEM_br_decision_o   = exmem_q.valid && exmem_q.decision;
    assign EXMEM_prediction_o    = exmem_q.valid && exmem_q.pred;

`ifdef BR_PERF_CNT_EN
    logic [31:0] perf_br_q, perf_br_d, perf_mis_q, perf_mis_d;

    always_comb begin
        perf_br_d  = perf_br_q;
        perf_mis_d = perf_mis_q;
        if (exmem_q.valid && exmem_q.is_jmp) begin
            if (perf_br_q != '1) perf_br_d = perf_br_q + 32'd1;
            if ((exmem_q.pred != exmem_q.decision) && (perf_mis_q != '1))
                perf_mis_d = perf_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_br_cnt_o      = perf_br_q;
    assign perf_mispred_cnt_o = perf_mis_q;
`else
    assign perf_br_cnt_o      = '0;
    assign perf_mispred_cnt_o = '0;
`endif

endmodule
